dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port dmem syncram between two requesters: port 0 is the processor load/store path and port 1 is the debug/loader path.
- Arbitration is per cycle, with fixed priority to port 0 and an anti-starvation counter that guarantees port 1 a slot.
- Tracks in-flight reads across the dmem read latency and returns q_dmem to the requester that issued each read.
- Sits between the processor/loader and the dmem instance, on dmem_clock's domain, with one clock.

Parameters:
ADDR_W, 12, dmem word-address width
DATA_W, 32, data width
RD_LAT, 1, cycles from accepted read to valid q_dmem (>=1)
MAX_CONSEC, 4, max consecutive port-0 grants while port 1 waits (>=1)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
req0  in  1  port 0 request
we0  in  1  port 0 write enable (0 = read)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 request accepted this cycle
rvalid0  out  1  port 0 read data valid
rdata0  out  DATA_W  port 0 read data
req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1  same as port 0, for port 1
address_dmem  out  ADDR_W  to dmem
data  out  DATA_W  to dmem
wren  out  1  to dmem
q_dmem  in  DATA_W  from dmem

Behaviour:
- Grant logic is combinational and evaluated every cycle:
  - force1 = req1 && (starve_cnt == MAX_CONSEC).
  - gnt0 = req0 && !force1.
  - gnt1 = req1 && (!req0 || force1).
  - gnt0 and gnt1 are never both 1.
- A request is accepted on the clock edge where gnt is high. An ungranted requester holds req/we/addr/wdata stable until granted.
- Memory mux:
  - address_dmem/data/wren come from the granted port, with wren = we & gnt.
  - With no grant: address_dmem=0, data=0, wren=0.
- starve_cnt, width clog2(MAX_CONSEC+1):
  - Resets to 0.
  - Increments (saturating) on edges with gnt0 && req1.
  - Clears on edges with gnt1 or !req1.
- Read tracker:
  - RD_LAT-deep shift register of {valid, owner}.
  - Each edge pushes valid = (gnt0|gnt1) & !we_granted, with owner = the granted port.
  - The tail entry drives rvalid0 = valid & owner==0 and rvalid1 = valid & owner==1.
  - rdata0 = rdata1 = q_dmem; consumers qualify with rvalid.
- Writes produce no rvalid.
- A read and a write can overlap: a write accepted while earlier reads are in flight does not disturb their return order or ownership.
- Throughput is one access per cycle with no bubbles. Back-to-back reads from alternating ports return in issue order.
- Reset (asynchronous, any time):
  - starve_cnt=0 and the tracker is cleared.
  - gnt0/gnt1 are forced 0 while reset is high, so wren=0 and address_dmem=0.
  - Reads in flight at reset never produce rvalid.
- Port 1 worst-case wait: MAX_CONSEC cycles of continuous port-0 requests, then one port-1 grant.

Optional Feature:
Macro DMEM_ARB_STATS_EN.
- Defined: adds outputs gcnt0[31:0], gcnt1[31:0] and conflict_cnt[31:0].
  - gcnt0/gcnt1 increment on each accepted grant per port.
  - conflict_cnt increments on edges where req0 && req1.
  - All three wrap at 2^32 and are cleared by reset.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - the owner typedef (OWNER_P0=0, OWNER_P1=1);
  - the tracker entry struct {valid, owner};
  - default constants DMEM_ADDR_W=12 and DMEM_DATA_W=32.
- One sub-module, dmem_arb_rdtrack: the RD_LAT-deep shift register producing rvalid0/rvalid1, with clock and reset passed through.

Test Plan:
- Port 0 write of 0xDEADBEEF to addr 0x010, then read of 0x010 → wren=1 on the write cycle, gnt0=1 both cycles, rvalid0=1 with rdata0=0xDEADBEEF RD_LAT cycles after the read, rvalid1 stays 0.
- req0 and req1 held high continuously, MAX_CONSEC=4 → grant pattern 0,0,0,0,1,0,0,0,0,1; starve_cnt returns to 0 after each gnt1.
- Alternating reads P0@0x001, P1@0x002, P0@0x003 with preloaded memory → rvalid0, rvalid1, rvalid0 on consecutive cycles, each carrying its own address's data.
- Port 1 read accepted, reset asserted on the next cycle before data returns → no rvalid1 ever fires; after release the first grant works normally.
- Idle (no req) → address_dmem=0, data=0, wren=0, gnt0=gnt1=0.
- With DMEM_ARB_STATS_EN, run 10 cycles of dual requests → gcnt0=8, gcnt1=2, conflict_cnt=10.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the dmem arbiter slice.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic {
    OWNER_P0 = 1'b0,
    OWNER_P1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } trk_entry_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports (0 = load/store, 1 = debug/loader) plus the dmem-side bus.
// Handshake: a request (req/we/addr/wdata) is accepted on the rising edge where
// gnt is high; until then the requester holds it stable. rvalid qualifies rdata.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) ();

  logic              req0, we0, gnt0, rvalid0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0, rdata0;
  logic              req1, we1, gnt1, rvalid1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1, rdata1;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data, q_dmem;
  logic              wren;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, q_dmem,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    output address_dmem, data, wren
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, q_dmem,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    input  address_dmem, data, wren
  );

endinterface

// File: rtl/dmem_arb_rdtrack.sv
// In-flight read tracker: RD_LAT-deep {valid, owner} pipe aligned with dmem latency.
module dmem_arb_rdtrack
  import dmem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  trk_entry_t push_i,
  output logic       rvalid0_o,
  output logic       rvalid1_o
);

  trk_entry_t pipe_q [RD_LAT];
  trk_entry_t tail;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '{valid: 1'b0, owner: OWNER_P0};
    end else begin
      pipe_q[0] <= push_i;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail      = pipe_q[RD_LAT-1];
  assign rvalid0_o = tail.valid && (tail.owner == OWNER_P0);
  assign rvalid1_o = tail.valid && (tail.owner == OWNER_P1);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port dmem: port 0 priority, port 1 anti-starvation.
// Optional grant/conflict statistics outputs when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int MAX_CONSEC = 4
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   gcnt0,
  output logic [31:0]   gcnt1,
  output logic [31:0]   conflict_cnt
`endif
);

  localparam int SC_W = $clog2(MAX_CONSEC + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(MAX_CONSEC);

  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic              force1, gnt0, gnt1, we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] data_sel;
  trk_entry_t        push;

  always_comb begin
    force1       = bus.req1 && (starve_cnt_q == SC_MAX);
    // Grants are suppressed during reset so dmem sees no write or address.
    gnt0         = !reset && bus.req0 && !force1;
    gnt1         = !reset && bus.req1 && (!bus.req0 || force1);
    addr_sel     = '0;
    data_sel     = '0;
    we_sel       = 1'b0;
    starve_cnt_d = starve_cnt_q;
    if (gnt0) begin
      addr_sel = bus.addr0;
      data_sel = bus.wdata0;
      we_sel   = bus.we0;
    end else if (gnt1) begin
      addr_sel = bus.addr1;
      data_sel = bus.wdata1;
      we_sel   = bus.we1;
    end
    if (gnt1 || !bus.req1) begin
      starve_cnt_d = '0;
    end else if (gnt0 && (starve_cnt_q != SC_MAX)) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
    push = '{valid: (gnt0 || gnt1) && !we_sel, owner: gnt1 ? OWNER_P1 : OWNER_P0};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end

  dmem_arb_rdtrack #(.RD_LAT(RD_LAT)) u_rdtrack (
    .clock     (clock),
    .reset     (reset),
    .push_i    (push),
    .rvalid0_o (bus.rvalid0),
    .rvalid1_o (bus.rvalid1)
  );

  assign bus.gnt0         = gnt0;
  assign bus.gnt1         = gnt1;
  assign bus.address_dmem = addr_sel;
  assign bus.data         = data_sel;
  assign bus.wren         = we_sel;
  assign bus.rdata0       = bus.q_dmem;
  assign bus.rdata1       = bus.q_dmem;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] gcnt0_q, gcnt1_q, conflict_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gcnt0_q        <= '0;
      gcnt1_q        <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (gnt0)                 gcnt0_q        <= gcnt0_q + 32'd1;
      if (gnt1)                 gcnt1_q        <= gcnt1_q + 32'd1;
      if (bus.req0 && bus.req1) conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign gcnt0        = gcnt0_q;
  assign gcnt1        = gcnt1_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural dmem and reference model.
// Stats checks are compiled in when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int RD_LAT     = 2;
  localparam int MAX_CONSEC = 4;
  localparam int MEM_WORDS  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] gcnt0, gcnt1, conflict_cnt;
`endif

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_CONSEC(MAX_CONSEC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
`ifdef DMEM_ARB_STATS_EN
    ,
    .gcnt0        (gcnt0),
    .gcnt1        (gcnt1),
    .conflict_cnt (conflict_cnt)
`endif
  );

  // ---------------- behavioural dmem ----------------
  function automatic logic [DATA_W-1:0] init_val(input int a);
    return {16'hC0DE, 16'(a)};
  endfunction

  logic              preload_en = 1'b1;
  logic [DATA_W-1:0] mem    [MEM_WORDS];
  logic [DATA_W-1:0] q_pipe [RD_LAT];

  always @(posedge clock) begin
    if (preload_en) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_val(i);
    end else if (bus.wren) begin
      mem[bus.address_dmem] <= bus.data;
    end
    q_pipe[0] <= mem[bus.address_dmem];
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign bus.q_dmem = q_pipe[RD_LAT-1];

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int waited   = 0;   // cycles port 1 has been kept waiting in a row
  logic [DATA_W:0]   exp_q[$];  // {owner, data}
  int                due_q[$];
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];
  logic obs_g0, obs_g1, mdl_g0, mdl_g1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_sample();
    logic e0, e1, ew;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic [DATA_W:0]   ent;
    obs_g0 = bus.gnt0;
    obs_g1 = bus.gnt1;
    if (reset) begin
      exp_q.delete();
      due_q.delete();
      waited = 0;
      mdl_g0 = 1'b0;
      mdl_g1 = 1'b0;
      check("rst_gnt",  {bus.gnt0, bus.gnt1}, 2'b00);
      check("rst_mem",  {bus.wren, bus.address_dmem}, '0);
      check("rst_rval", {bus.rvalid0, bus.rvalid1}, 2'b00);
      return;
    end
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      ent = exp_q.pop_front();
      check("rvalid", {bus.rvalid0, bus.rvalid1}, {!ent[DATA_W], ent[DATA_W]});
      if (ent[DATA_W]) check("rdata1", bus.rdata1, ent[DATA_W-1:0]);
      else             check("rdata0", bus.rdata0, ent[DATA_W-1:0]);
    end else begin
      check("no_rvalid", {bus.rvalid0, bus.rvalid1}, 2'b00);
    end
    e1 = bus.req1 && (!bus.req0 || waited >= MAX_CONSEC);
    e0 = bus.req0 && !e1;
    check("gnt", {bus.gnt0, bus.gnt1}, {e0, e1});
    check("starve", 64'(dut.starve_cnt_q), 64'(waited));
    ea = '0; ed = '0; ew = 1'b0;
    if (e0)      begin ea = bus.addr0; ed = bus.wdata0; ew = bus.we0; end
    else if (e1) begin ea = bus.addr1; ed = bus.wdata1; ew = bus.we1; end
    check("mem_bus", {bus.wren, bus.address_dmem, bus.data}, {ew, ea, ed});
    if ((e0 || e1) && !ew) begin
      due_q.push_back(cyc + RD_LAT);
      exp_q.push_back({e1, ref_mem[ea]});
    end
    if ((e0 || e1) && ew) ref_mem[ea] = ed;
    if (e1 || !bus.req1) waited = 0;
    else if (e0 && waited < MAX_CONSEC) waited++;
    mdl_g0 = e0;
    mdl_g1 = e1;
  endtask

  task automatic cycle();
    @(negedge clock);
    model_sample();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_p0(input logic req, input logic we, input int addr, input logic [DATA_W-1:0] wd);
    bus.req0 = req; bus.we0 = we; bus.addr0 = ADDR_W'(addr); bus.wdata0 = wd;
  endtask

  task automatic drive_p1(input logic req, input logic we, input int addr, input logic [DATA_W-1:0] wd);
    bus.req1 = req; bus.we1 = we; bus.addr1 = ADDR_W'(addr); bus.wdata1 = wd;
  endtask

  task automatic idle_all();
    drive_p0(1'b0, 1'b0, 0, '0);
    drive_p1(1'b0, 1'b0, 0, '0);
  endtask

  task automatic drain();
    idle_all();
    repeat (RD_LAT + 2) cycle();
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_val(i);
    idle_all();
    drive_p0(1'b1, 1'b1, 5, 32'h1234);   // must not be granted while in reset
    repeat (3) cycle();
    preload_en = 1'b0;
    idle_all();
    reset = 1'b0;
    repeat (2) cycle();                  // idle bus

    // port 0 write then read back
    drive_p0(1'b1, 1'b1, 'h010, 32'hDEADBEEF);
    cycle();
    check("wr_gnt0", obs_g0, 1'b1);
    drive_p0(1'b1, 1'b0, 'h010, '0);
    cycle();
    check("rd_gnt0", obs_g0, 1'b1);
    drain();

    // alternating single-port reads return in issue order
    drive_p0(1'b1, 1'b0, 'h001, '0);
    cycle();
    drive_p0(1'b0, 1'b0, 0, '0);
    drive_p1(1'b1, 1'b0, 'h002, '0);
    cycle();
    drive_p1(1'b0, 1'b0, 0, '0);
    drive_p0(1'b1, 1'b0, 'h003, '0);
    cycle();
    drain();

    // continuous contention from a fresh reset
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    drive_p0(1'b1, 1'b0, 'h020, '0);
    drive_p1(1'b1, 1'b0, 'h021, '0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("pattern", {obs_g0, obs_g1}, (i % 5 == 4) ? 2'b01 : 2'b10);
    end
    idle_all();
`ifdef DMEM_ARB_STATS_EN
    check("gcnt0", gcnt0, 32'd8);
    check("gcnt1", gcnt1, 32'd2);
    check("conflict_cnt", conflict_cnt, 32'd10);
`endif
    drain();

    // reset while a port-1 read is in flight
    drive_p1(1'b1, 1'b0, 'h030, '0);
    cycle();
    reset = 1'b1;
    drive_p1(1'b0, 1'b0, 0, '0);
    repeat (2) cycle();
    reset = 1'b0;
    repeat (RD_LAT + 2) cycle();
    drive_p1(1'b1, 1'b0, 'h031, '0);
    cycle();
    check("post_rst_gnt1", obs_g1, 1'b1);
    drain();

    // randomized traffic with hold-until-granted requesters
    for (int n = 0; n < 800; n++) begin
      if (!bus.req0 || mdl_g0)
        drive_p0($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 15)), $urandom);
      if (!bus.req1 || mdl_g1)
        drive_p1($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 15)), $urandom);
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
